mod_counter_chain: RTL and testbench

MOD_COUNTER_CHAIN -- requirements
Module: mod_counter_chain

---
 rtl/mod_counter_chain_pkg.sv | 15 +
 rtl/mod_digit.sv | 36 +++
 rtl/mod_counter_chain.sv | 64 ++++++
 tb/tb_mod_counter_chain.sv | 126 ++++++++++++
 4 files changed

// File: rtl/mod_counter_chain_pkg.sv
// Shared constants and helpers for the cascaded modulo counter.
// Digit width is derived from the modulus so BASE=2..16 packs into 1..4 bits.
package counter_pkg;

  localparam int DEF_DIGITS = 4;
  localparam int DEF_BASE   = 10;

  function automatic int digit_width(input int base);
    int w;
    w = 1;
    while ((1 << w) < base) w++;
    return w;
  endfunction

endpackage

// File: rtl/mod_digit.sv
// One modulo-BASE up/down digit with synchronous load and carry/borrow-out.
// term flags the wrap point for the current direction; carry is term qualified by en.
module mod_digit
  import counter_pkg::*;
#(
  parameter int BASE = DEF_BASE,
  parameter int W    = digit_width(BASE)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] count,
  output logic         term,
  output logic         carry
);

  localparam logic [W-1:0] MAX = W'(BASE - 1);

  assign term  = up ? (count == MAX) : (count == '0);
  assign carry = en & term;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en) begin
      if (up) count <= term ? '0 : count + 1'b1;
      else    count <= term ? MAX : count - 1'b1;
    end
  end

endmodule

// File: rtl/mod_counter_chain.sv
// DIGITS cascaded modulo-BASE digits with load clamping, terminal count and wrap pulse.
// Each digit steps only when every lower digit sits at its wrap point this cycle.
module mod_counter_chain
  import counter_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS,
  parameter int BASE   = DEF_BASE,
  localparam int W     = digit_width(BASE)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [DIGITS*W-1:0] load_value,
  output logic [DIGITS*W-1:0] count,
  output logic                tc,
  output logic                wrap,
  output logic                load_err
);

  localparam logic [W-1:0] MAX = W'(BASE - 1);

  logic [DIGITS:0]   en_chain;
  logic [DIGITS-1:0] over;
  logic [DIGITS-1:0] term;

  assign en_chain[0] = en;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    logic [W-1:0] raw;
    logic [W-1:0] clamped;

    assign raw     = load_value[k*W +: W];
    assign over[k] = (raw > MAX);
    assign clamped = over[k] ? MAX : raw;

    mod_digit #(.BASE(BASE), .W(W)) u_digit (
      .clk        (clk),
      .reset      (reset),
      .en         (en_chain[k]),
      .up         (up),
      .load       (load),
      .load_value (clamped),
      .count      (count[k*W +: W]),
      .term       (term[k]),
      .carry      (en_chain[k+1])
    );
  end

  // Full-chain terminal count is the carry out of the top digit.
  assign tc = en_chain[DIGITS];

  always_ff @(posedge clk) begin
    if (reset) begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= ~load & tc;
      load_err <= load & (|over);
    end
  end

endmodule

// File: tb/tb_mod_counter_chain.sv
// Directed vector bench for mod_counter_chain (DIGITS=4, BASE=10) plus a full up sweep.
module tb_mod_counter_chain;

  logic        clk = 1'b0;
  logic        reset, en, up, load;
  logic [15:0] load_value;
  logic [15:0] count;
  logic        tc, wrap, load_err;

  int checks = 0;
  int errors = 0;

  mod_counter_chain #(.DIGITS(4), .BASE(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .up         (up),
    .load       (load),
    .load_value (load_value),
    .count      (count),
    .tc         (tc),
    .wrap       (wrap),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  // ctl = {reset, load, en, up}; flg = {tc before edge, wrap after, load_err after}
  typedef struct {
    logic [3:0]  ctl;
    logic [15:0] lv;
    logic [2:0]  flg;
    logic [15:0] exp_count;
  } vec_t;

  vec_t vecs[27];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] bcd(input int n);
    logic [15:0] r;
    r[3:0]   = 4'(n % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[11:8]  = 4'((n / 100) % 10);
    r[15:12] = 4'((n / 1000) % 10);
    return r;
  endfunction

  int wraps;

  initial begin
    vecs[0]  = '{4'b1001, 16'h0000, 3'b000, 16'h0000};
    vecs[1]  = '{4'b0011, 16'h0000, 3'b000, 16'h0001};
    vecs[2]  = '{4'b0010, 16'h0000, 3'b000, 16'h0000};
    vecs[3]  = '{4'b0010, 16'h0000, 3'b110, 16'h9999};
    vecs[4]  = '{4'b0000, 16'h0000, 3'b000, 16'h9999};
    vecs[5]  = '{4'b0011, 16'h0000, 3'b110, 16'h0000};
    vecs[6]  = '{4'b0100, 16'h0999, 3'b000, 16'h0999};
    vecs[7]  = '{4'b0011, 16'h0000, 3'b000, 16'h1000};
    vecs[8]  = '{4'b0111, 16'h1000, 3'b000, 16'h1000};
    vecs[9]  = '{4'b0010, 16'h0000, 3'b000, 16'h0999};
    vecs[10] = '{4'b0111, 16'h0C5F, 3'b001, 16'h0959};
    vecs[11] = '{4'b0000, 16'h0000, 3'b000, 16'h0959};
    vecs[12] = '{4'b0100, 16'h4321, 3'b000, 16'h4321};
    vecs[13] = '{4'b1111, 16'h0999, 3'b000, 16'h0000};
    vecs[14] = '{4'b1010, 16'h0000, 3'b100, 16'h0000};
    vecs[15] = '{4'b0010, 16'h0000, 3'b110, 16'h9999};
    vecs[16] = '{4'b0100, 16'h0005, 3'b000, 16'h0005};
    vecs[17] = '{4'b0011, 16'h0000, 3'b000, 16'h0006};
    vecs[18] = '{4'b0010, 16'h0000, 3'b000, 16'h0005};
    vecs[19] = '{4'b0011, 16'h0000, 3'b000, 16'h0006};
    vecs[20] = '{4'b0100, 16'h9999, 3'b000, 16'h9999};
    vecs[21] = '{4'b0011, 16'h0000, 3'b110, 16'h0000};
    vecs[22] = '{4'b0111, 16'h9999, 3'b000, 16'h9999};
    vecs[23] = '{4'b0111, 16'h1234, 3'b100, 16'h1234};
    vecs[24] = '{4'b0000, 16'h0000, 3'b000, 16'h1234};
    vecs[25] = '{4'b0100, 16'hF000, 3'b001, 16'h9000};
    vecs[26] = '{4'b0000, 16'h0000, 3'b000, 16'h9000};

    reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_value = 16'h0;
    @(posedge clk); @(posedge clk); #1;
    check("reset_count", 32'(count), 32'h0);
    check("reset_wrap", 32'(wrap), 32'h0);
    check("reset_err", 32'(load_err), 32'h0);

    for (int i = 0; i < 27; i++) begin
      {reset, load, en, up} = vecs[i].ctl;
      load_value = vecs[i].lv;
      #3;
      check($sformatf("v%0d_tc", i), 32'(tc), 32'(vecs[i].flg[2]));
      @(posedge clk); #1;
      check($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      check($sformatf("v%0d_wrap", i), 32'(wrap), 32'(vecs[i].flg[1]));
      check($sformatf("v%0d_err", i), 32'(load_err), 32'(vecs[i].flg[0]));
    end

    // Full up sweep from reset: 0000..9999 then back to 0000 with one wrap pulse.
    reset = 1'b1; load = 1'b0; en = 1'b0; up = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; en = 1'b1;
    wraps = 0;
    for (int i = 0; i < 10000; i++) begin
      #3;
      check("sweep_tc", 32'(tc), 32'(i == 9999));
      @(posedge clk); #1;
      check("sweep_count", 32'(count), 32'(bcd((i + 1) % 10000)));
      check("sweep_wrap", 32'(wrap), 32'(i == 9999));
      if (wrap) wraps++;
    end
    check("sweep_wrap_total", 32'(wraps), 32'd1);
    en = 1'b0;
    @(posedge clk); #1;
    check("sweep_wrap_drop", 32'(wrap), 32'h0);
    check("sweep_hold", 32'(count), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
